axi4_lite_reg_slave: RTL and testbench

//  AXI4-Lite responder (slave) exposing a bank of REG_COUNT read/write registers to an AXI master.

---
 rtl/axi4_lite_reg_slave.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_reg_slave
//   AXI4-Lite responder that exposes REG_COUNT read/write registers. The
//   register contents are presented on a flat bus for fabric logic, and a
//   one-cycle pulse flags each register that is written.
//   The write and read channels run independently. Each channel has its own
//   two-state FSM and allows only one outstanding transaction.
//
// Parameters
//   C_AXI_DATA_WIDTH  data width, 32 or 64
//   C_AXI_ADDR_WIDTH  byte-address width
//   REG_COUNT         number of registers, 1..256
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW*                    write address channel (AWPROT ignored)
//   S_AXI_W*                     write data channel
//   S_AXI_B*                     write response channel
//   S_AXI_AR*                    read address channel (ARPROT ignored)
//   S_AXI_R*                     read data channel
//   REG_OUT                      register i at bits [i*DW +: DW]
//   REG_WR_PULSE                 bit i high for one cycle after reg i is written
// -----------------------------------------------------------------------------
module axi4_lite_reg_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int REG_COUNT        = 16
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [C_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic                                  S_AXI_AWVALID,
    output logic                                  S_AXI_AWREADY,
    input  logic [2:0]                            S_AXI_AWPROT,
    input  logic [C_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                                  S_AXI_WVALID,
    output logic                                  S_AXI_WREADY,
    output logic [1:0]                            S_AXI_BRESP,
    output logic                                  S_AXI_BVALID,
    input  logic                                  S_AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic                                  S_AXI_ARVALID,
    output logic                                  S_AXI_ARREADY,
    input  logic [2:0]                            S_AXI_ARPROT,
    output logic [C_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                            S_AXI_RRESP,
    output logic                                  S_AXI_RVALID,
    input  logic                                  S_AXI_RREADY,
    output logic [REG_COUNT*C_AXI_DATA_WIDTH-1:0] REG_OUT,
    output logic [REG_COUNT-1:0]                  REG_WR_PULSE
);

    localparam int DW       = C_AXI_DATA_WIDTH;
    localparam int STRB_W   = C_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = C_AXI_ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;

    // Merge the write data into the old register value, one byte lane per strobe bit.
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]     old_v,
                                                 input logic [DW-1:0]     new_v,
                                                 input logic [STRB_W-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Register bank
    logic [DW-1:0] reg_bank_r [REG_COUNT];

    // Write channel state
    wr_state_t            wr_state_r, wr_state_s;
    logic                 aw_done_r, aw_done_s;
    logic                 w_done_r, w_done_s;
    logic                 awready_r, awready_s;
    logic                 wready_r, wready_s;
    logic                 bvalid_r, bvalid_s;
    logic [1:0]           bresp_r, bresp_s;
    logic [IDX_W-1:0]     wr_idx_r, wr_idx_s;
    logic [DW-1:0]        wr_data_r, wr_data_s;
    logic [STRB_W-1:0]    wr_strb_r, wr_strb_s;
    logic [REG_COUNT-1:0] wr_pulse_r, wr_pulse_s;
    logic                 aw_hs_s, w_hs_s, wr_in_range_s, commit_s;

    // Read channel state
    rd_state_t            rd_state_r, rd_state_s;
    logic                 arready_r, arready_s;
    logic                 rvalid_r, rvalid_s;
    logic [1:0]           rresp_r, rresp_s;
    logic [DW-1:0]        rdata_r, rdata_s;
    logic [IDX_W-1:0]     rd_idx_s;
    logic [DW-1:0]        rd_mux_s;
    logic                 ar_hs_s, rd_in_range_s;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_s;
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs_s       = S_AXI_AWVALID & awready_r;
    assign w_hs_s        = S_AXI_WVALID & wready_r;
    assign wr_in_range_s = (wr_idx_r < IDX_W'(REG_COUNT));
    assign ar_hs_s       = S_AXI_ARVALID & arready_r;
    assign rd_idx_s      = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign rd_in_range_s = (rd_idx_s < IDX_W'(REG_COUNT));

    // Write FSM next state: latch AW and W independently, then commit once both are held.
    always_comb begin
        wr_state_s = wr_state_r;
        aw_done_s  = aw_done_r;
        w_done_s   = w_done_r;
        wr_idx_s   = wr_idx_r;
        wr_data_s  = wr_data_r;
        wr_strb_s  = wr_strb_r;
        bvalid_s   = bvalid_r;
        bresp_s    = bresp_r;
        wr_pulse_s = {REG_COUNT{1'b0}};
        commit_s   = 1'b0;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_done_s = 1'b1;
                    wr_idx_s  = S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
                end else begin
                    aw_done_s = aw_done_r;
                end
                if (w_hs_s) begin
                    w_done_s  = 1'b1;
                    wr_data_s = S_AXI_WDATA;
                    wr_strb_s = S_AXI_WSTRB;
                end else begin
                    w_done_s = w_done_r;
                end
                if (aw_done_r && w_done_r) begin
                    commit_s   = 1'b1;
                    wr_state_s = W_RESP;
                    aw_done_s  = 1'b0;
                    w_done_s   = 1'b0;
                    bvalid_s   = 1'b1;
                    if (wr_in_range_s) begin
                        bresp_s = RESP_OKAY;
                        for (int i = 0; i < REG_COUNT; i++) begin
                            wr_pulse_s[i] = (wr_idx_r == IDX_W'(i));
                        end
                    end else begin
                        bresp_s    = RESP_SLVERR;
                        wr_pulse_s = {REG_COUNT{1'b0}};
                    end
                end else begin
                    commit_s = 1'b0;
                end
            end
            W_RESP: begin
                if (bvalid_r && S_AXI_BREADY) begin
                    wr_state_s = W_IDLE;
                    bvalid_s   = 1'b0;
                end else begin
                    wr_state_s = W_RESP;
                end
            end
            default: begin
                wr_state_s = W_IDLE;
                aw_done_s  = 1'b0;
                w_done_s   = 1'b0;
                bvalid_s   = 1'b0;
            end
        endcase
        // Ready flags are registered so they reflect the state being entered.
        awready_s = (wr_state_s == W_IDLE) && !aw_done_s;
        wready_s  = (wr_state_s == W_IDLE) && !w_done_s;
    end

    // Write FSM and write-channel output registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_r <= W_IDLE;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            wr_idx_r   <= {IDX_W{1'b0}};
            wr_data_r  <= {DW{1'b0}};
            wr_strb_r  <= {STRB_W{1'b0}};
            wr_pulse_r <= {REG_COUNT{1'b0}};
        end else begin
            wr_state_r <= wr_state_s;
            aw_done_r  <= aw_done_s;
            w_done_r   <= w_done_s;
            awready_r  <= awready_s;
            wready_r   <= wready_s;
            bvalid_r   <= bvalid_s;
            bresp_r    <= bresp_s;
            wr_idx_r   <= wr_idx_s;
            wr_data_r  <= wr_data_s;
            wr_strb_r  <= wr_strb_s;
            wr_pulse_r <= wr_pulse_s;
        end
    end

    // Register bank update on an in-range commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_bank_r[i] <= {DW{1'b0}};
            end
        end else if (commit_s && wr_in_range_s) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_idx_r == IDX_W'(i)) begin
                    reg_bank_r[i] <= apply_strb(reg_bank_r[i], wr_data_r, wr_strb_r);
                end
            end
        end
    end

    // Read mux: OR of the selected register, zero when the index matches nothing.
    always_comb begin
        rd_mux_s = {DW{1'b0}};
        for (int i = 0; i < REG_COUNT; i++) begin
            rd_mux_s = rd_mux_s | ((rd_idx_s == IDX_W'(i)) ? reg_bank_r[i] : {DW{1'b0}});
        end
    end

    // Read FSM next state: the response is captured on the AR handshake edge.
    always_comb begin
        rd_state_s = rd_state_r;
        rvalid_s   = rvalid_r;
        rdata_s    = rdata_r;
        rresp_s    = rresp_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_s = R_RESP;
                    rvalid_s   = 1'b1;
                    if (rd_in_range_s) begin
                        rdata_s = rd_mux_s;
                        rresp_s = RESP_OKAY;
                    end else begin
                        rdata_s = {DW{1'b0}};
                        rresp_s = RESP_SLVERR;
                    end
                end else begin
                    rvalid_s = 1'b0;
                end
            end
            R_RESP: begin
                if (rvalid_r && S_AXI_RREADY) begin
                    rd_state_s = R_IDLE;
                    rvalid_s   = 1'b0;
                end else begin
                    rd_state_s = R_RESP;
                end
            end
            default: begin
                rd_state_s = R_IDLE;
                rvalid_s   = 1'b0;
            end
        endcase
        arready_s = (rd_state_s == R_IDLE);
    end

    // Read FSM and read-channel output registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= {DW{1'b0}};
            rresp_r    <= 2'b00;
        end else begin
            rd_state_r <= rd_state_s;
            arready_r  <= arready_s;
            rvalid_r   <= rvalid_s;
            rdata_r    <= rdata_s;
            rresp_r    <= rresp_s;
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign REG_WR_PULSE  = wr_pulse_r;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_out
        assign REG_OUT[g*DW +: DW] = reg_bank_r[g];
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
module tb_axi4_lite_reg_slave;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int NREG  = 16;
    localparam int BUS_W = NREG * DW;

    logic              aclk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [2:0]        awprot;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [2:0]        arprot;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [BUS_W-1:0]  reg_out;
    logic [NREG-1:0]   reg_wr_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the register array as seen by the master.
    logic [DW-1:0] model_regs [NREG];

    always #5 aclk = ~aclk;

    axi4_lite_reg_slave #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .REG_COUNT(NREG)
    ) dut (
        .S_AXI_ACLK(aclk),     .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_AWPROT(awprot),
        .S_AXI_WDATA(wdata),   .S_AXI_WSTRB(wstrb),     .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),   .S_AXI_BVALID(bvalid),   .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_ARPROT(arprot),
        .S_AXI_RDATA(rdata),   .S_AXI_RRESP(rresp),     .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .REG_OUT(reg_out),     .REG_WR_PULSE(reg_wr_pulse)
    );

    task automatic check(input string name, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] model_flat();
        logic [BUS_W-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*DW +: DW] = model_regs[i];
        return f;
    endfunction

    function automatic bit in_range(input logic [AW-1:0] addr);
        return (addr / 4) < NREG;
    endfunction

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Full write transaction; starts and ends on a falling edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] bresp_seen);
        int   cyc;
        bit   aw_ok, w_ok, hs_aw, hs_w;
        logic [1:0]      exp_resp;
        logic [NREG-1:0] exp_pulse;
        int   idx;
        cyc = 0; aw_ok = 0; w_ok = 0;
        idx = int'(addr / 4);
        bresp_seen = 2'b11;
        while (!(aw_ok && w_ok) && cyc < 40) begin
            awvalid = !aw_ok && (cyc >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_ok && (cyc >= w_dly);
            wdata   = data;
            wstrb   = strb;
            check(aw_ok ? "awready_held_low" : "awready_idle", {511'd0, awready}, {511'd0, !aw_ok});
            check(w_ok ? "wready_held_low" : "wready_idle", {511'd0, wready}, {511'd0, !w_ok});
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge aclk);
            if (hs_aw) aw_ok = 1;
            if (hs_w)  w_ok = 1;
            @(negedge aclk);
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_ok && w_ok)) begin
            check("write_handshake_timeout", 512'd0, 512'd1);
            return;
        end
        // One cycle after the last handshake: no response yet, registers unchanged.
        check("bvalid_not_early", {511'd0, bvalid}, 512'd0);
        check("reg_out_before_commit", reg_out, model_flat());
        tick();
        exp_resp  = in_range(addr) ? 2'b00 : 2'b10;
        exp_pulse = in_range(addr) ? (NREG'(1) << idx) : '0;
        if (in_range(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        check("bvalid_latency", {511'd0, bvalid}, 512'd1);
        check("bresp", {510'd0, bresp}, {510'd0, exp_resp});
        check("wr_pulse", {496'd0, reg_wr_pulse}, {496'd0, exp_pulse});
        check("reg_out_after_commit", reg_out, model_flat());
        bresp_seen = bresp;
        for (int k = 0; k < b_dly; k++) begin
            tick();
            check("bvalid_hold", {511'd0, bvalid}, 512'd1);
            check("bresp_hold", {510'd0, bresp}, {510'd0, exp_resp});
            check("awready_in_resp", {510'd0, awready, wready}, 512'd0);
            check("wr_pulse_one_cycle", {496'd0, reg_wr_pulse}, 512'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_cleared", {511'd0, bvalid}, 512'd0);
        check("ready_after_b", {510'd0, awready, wready}, 512'd3);
        check("wr_pulse_cleared", {496'd0, reg_wr_pulse}, 512'd0);
    endtask

    // Full read transaction; starts and ends on a falling edge.
    task automatic do_read(input logic [AW-1:0] addr, input int r_dly,
                           output logic [DW-1:0] rdata_seen, output logic [1:0] rresp_seen);
        int   cyc;
        bit   done, hs;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
        cyc = 0; done = 0;
        rdata_seen = '0; rresp_seen = 2'b11;
        exp_data = in_range(addr) ? model_regs[int'(addr / 4)] : '0;
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        arvalid = 1'b1;
        araddr  = addr;
        while (!done && cyc < 40) begin
            hs = arready;
            @(posedge aclk);
            if (hs) done = 1;
            @(negedge aclk);
            cyc++;
        end
        arvalid = 1'b0;
        if (!done) begin
            check("read_handshake_timeout", 512'd0, 512'd1);
            return;
        end
        check("rvalid_latency", {511'd0, rvalid}, 512'd1);
        check("rdata", {480'd0, rdata}, {480'd0, exp_data});
        check("rresp", {510'd0, rresp}, {510'd0, exp_resp});
        check("arready_in_resp", {511'd0, arready}, 512'd0);
        rdata_seen = rdata;
        rresp_seen = rresp;
        for (int k = 0; k < r_dly; k++) begin
            tick();
            check("rvalid_hold", {511'd0, rvalid}, 512'd1);
            check("rdata_hold", {480'd0, rdata}, {480'd0, exp_data});
            check("rresp_hold", {510'd0, rresp}, {510'd0, exp_resp});
            check("arready_hold_low", {511'd0, arready}, 512'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_cleared", {511'd0, rvalid}, 512'd0);
        check("arready_after_r", {511'd0, arready}, 512'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {509'd0, awready, wready, arready}, 512'd0);
        check({tag, "_valid"}, {510'd0, bvalid, rvalid}, 512'd0);
        check({tag, "_resp"}, {508'd0, bresp, rresp}, 512'd0);
        check({tag, "_rdata"}, {480'd0, rdata}, 512'd0);
        check({tag, "_reg_out"}, reg_out, 512'd0);
        check({tag, "_pulse"}, {496'd0, reg_wr_pulse}, 512'd0);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        int            aw_dly;
        int            w_dly;
        int            b_dly;
        int            r_dly;
        logic [1:0]    exp_bresp;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_rresp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    bresp_seen, rresp_seen;
        logic [DW-1:0] rdata_seen;

        vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h0000_0004, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 2'b00, 32'h1234_5678, 2'b00};
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFF, 2'b00};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 4'h5, 0, 0, 0, 0, 2'b00, 32'hFF00_FF00, 2'b00};
        vecs[4] = '{32'h0000_0040, 32'hAAAA_5555, 4'hF, 0, 0, 0, 0, 2'b10, 32'h0000_0000, 2'b10};
        vecs[5] = '{32'h0000_000C, 32'h0A0B_0C0D, 4'hF, 0, 0, 5, 5, 2'b00, 32'h0A0B_0C0D, 2'b00};
        vecs[6] = '{32'h0000_003F, 32'h1122_3344, 4'hC, 1, 0, 1, 1, 2'b00, 32'h1122_0000, 2'b00};
        vecs[7] = '{32'h0000_0014, 32'hCAFE_F00D, 4'hF, 0, 2, 0, 2, 2'b00, 32'hCAFE_F00D, 2'b00};
        vecs[8] = '{32'hFFFF_FFFC, 32'h55AA_55AA, 4'hF, 1, 1, 2, 0, 2'b10, 32'h0000_0000, 2'b10};

        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; awprot = 3'd0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; arprot = 3'd0; rready = 1'b0;

        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        #1;
        check("ready_before_first_clock", {509'd0, awready, wready, arready}, 512'd0);
        @(negedge aclk);
        check("ready_after_release", {509'd0, awready, wready, arready}, 512'd7);

        // Directed vectors: write then read back each entry.
        for (int v = 0; v < 9; v++) begin
            do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly,
                     vecs[v].w_dly, vecs[v].b_dly, bresp_seen);
            check($sformatf("vec%0d_bresp", v), {510'd0, bresp_seen}, {510'd0, vecs[v].exp_bresp});
            do_read(vecs[v].addr, vecs[v].r_dly, rdata_seen, rresp_seen);
            check($sformatf("vec%0d_rdata", v), {480'd0, rdata_seen}, {480'd0, vecs[v].exp_rdata});
            check($sformatf("vec%0d_rresp", v), {510'd0, rresp_seen}, {510'd0, vecs[v].exp_rresp});
        end

        // Reset in the middle of a write: AW accepted, W never sent.
        awvalid = 1'b1;
        awaddr  = 32'h0000_0010;
        tick();
        awvalid = 1'b0;
        check("midwrite_awready_low", {510'd0, awready, wready}, 512'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        check_reset_outputs("midwrite_reset");
        repeat (2) @(negedge aclk);
        rst_n = 1'b1;
        @(negedge aclk);
        check("ready_after_midwrite_reset", {509'd0, awready, wready, arready}, 512'd7);
        check("no_commit_after_abandon", reg_out, 512'd0);
        do_write(32'h0000_0010, 32'h0BAD_F00D, 4'hF, 0, 0, 0, bresp_seen);
        do_read(32'h0000_0010, 0, rdata_seen, rresp_seen);
        check("post_reset_readback", {480'd0, rdata_seen}, {480'd0, 32'h0BAD_F00D});

        // Randomized traffic checked against the model.
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, NREG + 3) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2), bresp_seen);
            end else begin
                do_read(a, $urandom_range(0, 2), rdata_seen, rresp_seen);
            end
        end
        check("final_reg_out", reg_out, model_flat());

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
